pll_cfg_loader: RTL and testbench
=================================

Name: pll_cfg_loader

Overview:
Parametrised successor to the single-channel PLL reconfiguration RAM. Holds PROFILES reconfiguration profiles of up to WORDS entries each, written by the host. On request, it streams the selected profile into the PLL reconfiguration management port, issues START, then polls STATUS until the PLL reports done or a timeout expires. Sits between the sys_top control logic and the PLL reconfig core, on the 50 MHz system clock.

Parameters:
DATA_W, 9, width of each reconfig data word (matches existing RD_DATA width)
ADDR_W, 6, width of management-port register address
PROFILES, 4, number of stored profiles (power of 2, >=2)
WORDS, 8, max entries per profile (power of 2, >=2)
START_ADDR, 6'h02, management register written to launch reconfig
STATUS_ADDR, 6'h01, management register polled; bit0=1 means done
TIMEOUT, 1023, max poll reads before error

Ports:
CLOCK  in  1  system clock
RESET  in  1  synchronous, active-high reset
WE  in  1  table write strobe
WR_PROFILE  in  log2(PROFILES)  table write profile select
WR_INDEX  in  log2(WORDS)  table write entry index
WR_ENTRY  in  ADDR_W+DATA_W  {reg addr, data}; addr all-ones = end marker
LOAD_REQ  in  1  start-load pulse (sampled in IDLE only)
LOAD_PROFILE  in  log2(PROFILES)  profile to load
BUSY  out  1  high from LOAD_REQ acceptance until DONE/ERROR
DONE  out  1  one-cycle pulse on successful completion
ERROR  out  1  sticky timeout flag; cleared by next accepted LOAD_REQ or RESET
MGMT_ADDRESS  out  ADDR_W  management address
MGMT_WRITEDATA  out  DATA_W  management write data
MGMT_WRITE  out  1  write request
MGMT_READ  out  1  read request
MGMT_READDATA  in  DATA_W  read data, valid when MGMT_READ & !MGMT_WAITREQUEST
MGMT_WAITREQUEST  in  1  stall; request and address/data held while high

Behaviour:
- Reset: all outputs 0, FSM=IDLE, index=0, poll count=0. Table contents not cleared (no reset on RAM).
- Table: single-port-write/single-read synchronous RAM, PROFILES*WORDS entries, 1-cycle read latency. WE is honoured in every state; writes to the profile being loaded in the same cycle as its read return old data.
- FSM states: IDLE, FETCH, WRITE, START, POLL, DONE, ERR.
- IDLE: LOAD_REQ=1 -> latch LOAD_PROFILE, index=0, clear ERROR, BUSY=1, -> FETCH. LOAD_REQ outside IDLE ignored.
- FETCH: issue RAM read at {profile,index}; one cycle later -> WRITE with entry registered.
- WRITE: if entry addr == all-ones -> START (no write issued). Else assert MGMT_WRITE with address/data; hold until MGMT_WAITREQUEST=0; on that cycle deassert next cycle; if index==WORDS-1 -> START, else index++ -> FETCH. Min 3 cycles per entry with waitrequest low.
- START: MGMT_WRITE to START_ADDR, data=1, held through waitrequest; -> POLL, poll count=0.
- POLL: MGMT_READ to STATUS_ADDR held through waitrequest. On completion cycle: readdata[0]=1 -> DONE; else poll count++; if count reaches TIMEOUT -> ERR; else re-issue read next cycle after one idle cycle (READ low for one cycle between polls).
- DONE: DONE=1 for exactly one cycle, BUSY=0 same cycle, -> IDLE.
- ERR: ERROR=1 (sticky), BUSY=0, -> IDLE. No DONE pulse.
- MGMT_WRITE and MGMT_READ never both high. Outputs registered.
- RESET mid-transfer: abandon immediately, outputs 0 next cycle, no further management traffic.
- Profile with end marker at index 0: no data writes; START still issued.
- Counters sized for TIMEOUT with no wrap; index wrap impossible (bounded by WORDS-1 check).

Decomposition:
- Package pll_cfg_pkg: FSM state enum, END_MARKER constant (all-ones ADDR_W), entry field-slice helpers.
- One sub-module: pll_cfg_table (parametrised sync RAM, write port + registered read port).

Test Plan:
- Write profile 1 = {(0x03,0x1A5),(0x04,0x0FF),END}; LOAD_REQ profile 1, waitrequest=0 -> writes 0x03/0x1A5, 0x04/0x0FF, START_ADDR/1, one status read returning 1 -> DONE pulse, BUSY low same cycle.
- Same profile with MGMT_WAITREQUEST high 4 cycles on first write -> address/data held stable 5 cycles, exactly one write accepted, sequence otherwise identical.
- Full profile 2 (8 entries, no marker) -> 8 writes then START; status returns 0 twice then 1 -> 3 reads, READ low one cycle between, DONE.
- Status held 0, TIMEOUT=1023 -> exactly 1023 reads, ERROR=1, no DONE; next LOAD_REQ clears ERROR.
- RESET asserted during 2nd data write -> next cycle all outputs 0, FSM IDLE; subsequent load of profile 1 completes normally.
- LOAD_REQ pulsed while BUSY, and WE to active profile mid-load -> request ignored; load finishes without glitch.

Source files
------------

// File: rtl/pll_cfg_pkg.sv
// Shared definitions for the PLL reconfiguration loader.
// Contents: the loader FSM state type, default field widths, the end-marker
// constant and helpers that build or split a {reg addr, data} table entry.
package pll_cfg_pkg;

    localparam int unsigned CFG_ADDR_W  = 6;
    localparam int unsigned CFG_DATA_W  = 9;
    localparam int unsigned CFG_ENTRY_W = CFG_ADDR_W + CFG_DATA_W;

    // An entry whose address field is all ones terminates a profile early.
    localparam logic [CFG_ADDR_W-1:0] END_MARKER = {CFG_ADDR_W{1'b1}};

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StWrite,
        StStart,
        StPoll,
        StDone,
        StErr
    } state_t;

    function automatic logic [CFG_ENTRY_W-1:0] make_entry(input logic [CFG_ADDR_W-1:0] addr,
                                                          input logic [CFG_DATA_W-1:0] data);
        return {addr, data};
    endfunction

    function automatic logic [CFG_ADDR_W-1:0] entry_addr(input logic [CFG_ENTRY_W-1:0] entry);
        return entry[CFG_ENTRY_W-1:CFG_DATA_W];
    endfunction

    function automatic logic [CFG_DATA_W-1:0] entry_data(input logic [CFG_ENTRY_W-1:0] entry);
        return entry[CFG_DATA_W-1:0];
    endfunction

endpackage

// File: rtl/pll_cfg_table.sv
// Profile storage RAM: one synchronous write port, one registered read port.
// Ports:
//   clk    - clock
//   we     - write strobe, waddr/wdata - write address and entry
//   re     - read enable, raddr - read address
//   rdata  - read data, valid the cycle after re
// No reset on the array or read register; a same-cycle write and read of one
// location returns the previous contents.
module pll_cfg_table
    import pll_cfg_pkg::*;
#(
    parameter int unsigned WIDTH     = CFG_ENTRY_W,
    parameter int unsigned ADDR_BITS = 5
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] waddr,
    input  logic [WIDTH-1:0]     wdata,
    input  logic                 re,
    input  logic [ADDR_BITS-1:0] raddr,
    output logic [WIDTH-1:0]     rdata
);

    logic [WIDTH-1:0] mem [2**ADDR_BITS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/pll_cfg_loader.sv
// Streams a stored reconfiguration profile into the PLL management port,
// launches reconfiguration and polls status until done or timeout.
// Ports:
//   CLOCK, RESET              - clock, synchronous active-high reset
//   WE/WR_PROFILE/WR_INDEX/WR_ENTRY - host table write port
//   LOAD_REQ/LOAD_PROFILE     - load request, accepted only when idle
//   BUSY/DONE/ERROR           - status (DONE one-cycle pulse, ERROR sticky)
//   MGMT_*                    - PLL reconfig management master port
module pll_cfg_loader
    import pll_cfg_pkg::*;
#(
    parameter int unsigned         DATA_W      = CFG_DATA_W,
    parameter int unsigned         ADDR_W      = CFG_ADDR_W,
    parameter int unsigned         PROFILES    = 4,
    parameter int unsigned         WORDS       = 8,
    parameter logic [ADDR_W-1:0]   START_ADDR  = 6'h02,
    parameter logic [ADDR_W-1:0]   STATUS_ADDR = 6'h01,
    parameter int unsigned         TIMEOUT     = 1023
) (
    input  logic                        CLOCK,
    input  logic                        RESET,
    input  logic                        WE,
    input  logic [$clog2(PROFILES)-1:0] WR_PROFILE,
    input  logic [$clog2(WORDS)-1:0]    WR_INDEX,
    input  logic [ADDR_W+DATA_W-1:0]    WR_ENTRY,
    input  logic                        LOAD_REQ,
    input  logic [$clog2(PROFILES)-1:0] LOAD_PROFILE,
    output logic                        BUSY,
    output logic                        DONE,
    output logic                        ERROR,
    output logic [ADDR_W-1:0]           MGMT_ADDRESS,
    output logic [DATA_W-1:0]           MGMT_WRITEDATA,
    output logic                        MGMT_WRITE,
    output logic                        MGMT_READ,
    input  logic [DATA_W-1:0]           MGMT_READDATA,
    input  logic                        MGMT_WAITREQUEST
);

    localparam int unsigned PROF_W  = $clog2(PROFILES);
    localparam int unsigned IDX_W   = $clog2(WORDS);
    localparam int unsigned ENTRY_W = ADDR_W + DATA_W;
    localparam int unsigned CNT_W   = $clog2(TIMEOUT + 1);

    state_t              state_q, state_d;
    logic [PROF_W-1:0]   prof_q, prof_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                rd_pend_q, rd_pend_d;  // second FETCH cycle: RAM data valid
    logic                gap_q, gap_d;          // idle cycle between status polls
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                write_q, write_d;
    logic                read_q, read_d;

    logic [ENTRY_W-1:0]  rd_entry;
    logic                rd_en;
    logic                rd_is_end;
    logic                cur_is_end;
    logic                last_idx;
    logic                timeout_hit;
    logic                unused_rdata;

    assign rd_en       = (state_q == StFetch) && !rd_pend_q;
    assign rd_is_end   = &rd_entry[ENTRY_W-1:DATA_W];
    assign cur_is_end  = &addr_q;
    assign last_idx    = (idx_q == IDX_W'(WORDS - 1));
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));
    assign unused_rdata = ^MGMT_READDATA[DATA_W-1:1];

    pll_cfg_table #(
        .WIDTH     (ENTRY_W),
        .ADDR_BITS (PROF_W + IDX_W)
    ) u_table (
        .clk   (CLOCK),
        .we    (WE),
        .waddr ({WR_PROFILE, WR_INDEX}),
        .wdata (WR_ENTRY),
        .re    (rd_en),
        .raddr ({prof_q, idx_q}),
        .rdata (rd_entry)
    );

    // State and registered outputs.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q   <= StIdle;
            prof_q    <= '0;
            idx_q     <= '0;
            rd_pend_q <= 1'b0;
            gap_q     <= 1'b0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            write_q   <= 1'b0;
            read_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            prof_q    <= prof_d;
            idx_q     <= idx_d;
            rd_pend_q <= rd_pend_d;
            gap_q     <= gap_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            error_q   <= error_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            write_q   <= write_d;
            read_q    <= read_d;
        end
    end

    // Next state and sequencing counters.
    always_comb begin
        state_d   = state_q;
        prof_d    = prof_q;
        idx_d     = idx_q;
        rd_pend_d = rd_pend_q;
        gap_d     = gap_q;
        cnt_d     = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (LOAD_REQ) begin
                    prof_d    = LOAD_PROFILE;
                    idx_d     = '0;
                    rd_pend_d = 1'b0;
                    state_d   = StFetch;
                end
            end
            StFetch: begin
                rd_pend_d = !rd_pend_q;
                if (rd_pend_q) begin
                    state_d = StWrite;
                end
            end
            StWrite: begin
                if (cur_is_end) begin
                    state_d = StStart;
                end else if (!MGMT_WAITREQUEST) begin
                    if (last_idx) begin
                        state_d = StStart;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = StFetch;
                    end
                end
            end
            StStart: begin
                if (!MGMT_WAITREQUEST) begin
                    cnt_d   = '0;
                    gap_d   = 1'b0;
                    state_d = StPoll;
                end
            end
            StPoll: begin
                if (gap_q) begin
                    gap_d = 1'b0;
                end else if (!MGMT_WAITREQUEST) begin
                    if (MGMT_READDATA[0]) begin
                        state_d = StDone;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                        if (timeout_hit) begin
                            state_d = StErr;
                        end else begin
                            gap_d = 1'b1;
                        end
                    end
                end
            end
            StDone:  state_d = StIdle;
            StErr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Next values of the registered outputs, so each output is valid in the
    // first cycle of the state that owns it.
    always_comb begin
        busy_d  = busy_q;
        done_d  = 1'b0;
        error_d = error_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        write_d = 1'b0;
        read_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (LOAD_REQ) begin
                    busy_d  = 1'b1;
                    error_d = 1'b0;
                end
            end
            StFetch: begin
                if (rd_pend_q) begin
                    addr_d  = rd_entry[ENTRY_W-1:DATA_W];
                    wdata_d = rd_entry[DATA_W-1:0];
                    write_d = !rd_is_end;
                end
            end
            StWrite: begin
                if (cur_is_end || (!MGMT_WAITREQUEST && last_idx)) begin
                    addr_d  = START_ADDR;
                    wdata_d = DATA_W'(1);
                    write_d = 1'b1;
                end else if (MGMT_WAITREQUEST) begin
                    write_d = 1'b1;
                end
            end
            StStart: begin
                if (MGMT_WAITREQUEST) begin
                    write_d = 1'b1;
                end else begin
                    addr_d  = STATUS_ADDR;
                    wdata_d = '0;
                    read_d  = 1'b1;
                end
            end
            StPoll: begin
                if (gap_q || MGMT_WAITREQUEST) begin
                    read_d = 1'b1;
                end else if (MGMT_READDATA[0]) begin
                    done_d = 1'b1;
                    busy_d = 1'b0;
                end else if (timeout_hit) begin
                    error_d = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            StDone:  busy_d = 1'b0;
            StErr:   busy_d = 1'b0;
            default: busy_d = 1'b0;
        endcase
    end

    assign BUSY           = busy_q;
    assign DONE           = done_q;
    assign ERROR          = error_q;
    assign MGMT_ADDRESS   = addr_q;
    assign MGMT_WRITEDATA = wdata_q;
    assign MGMT_WRITE     = write_q;
    assign MGMT_READ      = read_q;

endmodule

// File: tb/tb_pll_cfg_loader.sv
module tb_pll_cfg_loader;
    import pll_cfg_pkg::*;

    localparam int TIMEOUT = 1023;

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b1;
    logic        WE = 1'b0;
    logic [1:0]  WR_PROFILE = '0;
    logic [2:0]  WR_INDEX = '0;
    logic [14:0] WR_ENTRY = '0;
    logic        LOAD_REQ = 1'b0;
    logic [1:0]  LOAD_PROFILE = '0;
    logic        BUSY, DONE, ERROR;
    logic [5:0]  MGMT_ADDRESS;
    logic [8:0]  MGMT_WRITEDATA;
    logic        MGMT_WRITE, MGMT_READ;
    logic [8:0]  MGMT_READDATA = '0;
    logic        MGMT_WAITREQUEST = 1'b0;

    pll_cfg_loader #(
        .TIMEOUT (TIMEOUT)
    ) dut (
        .CLOCK            (CLOCK),
        .RESET            (RESET),
        .WE               (WE),
        .WR_PROFILE       (WR_PROFILE),
        .WR_INDEX         (WR_INDEX),
        .WR_ENTRY         (WR_ENTRY),
        .LOAD_REQ         (LOAD_REQ),
        .LOAD_PROFILE     (LOAD_PROFILE),
        .BUSY             (BUSY),
        .DONE             (DONE),
        .ERROR            (ERROR),
        .MGMT_ADDRESS     (MGMT_ADDRESS),
        .MGMT_WRITEDATA   (MGMT_WRITEDATA),
        .MGMT_WRITE       (MGMT_WRITE),
        .MGMT_READ        (MGMT_READ),
        .MGMT_READDATA    (MGMT_READDATA),
        .MGMT_WAITREQUEST (MGMT_WAITREQUEST)
    );

    always #10 CLOCK = ~CLOCK;

    int n_checks = 0;
    int n_errors = 0;

    // Shadow of table contents as written by the bench.
    logic [5:0] sh_addr [4][8];
    logic [8:0] sh_data [4][8];

    // Management-port slave model and protocol monitor (all at negedge).
    int         zeros_cfg = 0;
    int         wait_left = 0;
    int         reads_seen = 0;
    int         wr_cnt = 0;
    int         stall_cnt = 0;
    int         viol_both = 0;
    int         viol_gap = 0;
    int         viol_hold = 0;
    logic [5:0] wr_addr_log [16];
    logic [8:0] wr_data_log [16];
    logic       gap_expect = 1'b0;
    logic       prev_stall = 1'b0;
    logic [5:0] prev_a = '0;
    logic [8:0] prev_d = '0;

    always @(negedge CLOCK) begin
        if (MGMT_WRITE && MGMT_READ) viol_both++;
        if (prev_stall && (!MGMT_WRITE || MGMT_ADDRESS != prev_a || MGMT_WRITEDATA != prev_d))
            viol_hold++;
        if (gap_expect && MGMT_READ) viol_gap++;
        if (wait_left > 0 && MGMT_WRITE) begin
            MGMT_WAITREQUEST = 1'b1;
            wait_left--;
            stall_cnt++;
        end else begin
            MGMT_WAITREQUEST = 1'b0;
        end
        MGMT_READDATA = (reads_seen >= zeros_cfg) ? 9'h001 : 9'h000;
        gap_expect = MGMT_READ && !MGMT_WAITREQUEST && !MGMT_READDATA[0];
        if (MGMT_READ && !MGMT_WAITREQUEST) reads_seen++;
        if (MGMT_WRITE && !MGMT_WAITREQUEST) begin
            if (wr_cnt < 16) begin
                wr_addr_log[wr_cnt] = MGMT_ADDRESS;
                wr_data_log[wr_cnt] = MGMT_WRITEDATA;
            end
            wr_cnt++;
        end
        prev_stall = MGMT_WRITE && MGMT_WAITREQUEST;
        prev_a = MGMT_ADDRESS;
        prev_d = MGMT_WRITEDATA;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string name);
        check({name, " BUSY"}, int'(BUSY), 0);
        check({name, " DONE"}, int'(DONE), 0);
        check({name, " ERROR"}, int'(ERROR), 0);
        check({name, " WRITE"}, int'(MGMT_WRITE), 0);
        check({name, " READ"}, int'(MGMT_READ), 0);
        check({name, " ADDRESS"}, int'(MGMT_ADDRESS), 0);
        check({name, " WRITEDATA"}, int'(MGMT_WRITEDATA), 0);
    endtask

    task automatic write_entry(input int prof, input int idx, input logic [5:0] a,
                               input logic [8:0] d);
        @(negedge CLOCK);
        WE = 1'b1;
        WR_PROFILE = 2'(prof);
        WR_INDEX = 3'(idx);
        WR_ENTRY = make_entry(a, d);
        sh_addr[prof][idx] = a;
        sh_data[prof][idx] = d;
        @(negedge CLOCK);
        WE = 1'b0;
    endtask

    task automatic run_load(input int prof, input int zeros, input int waitc,
                            input bit exp_err, input bit mid);
        int got;
        int n;
        logic [5:0] ea [9];
        logic [8:0] ed [9];
        @(negedge CLOCK);
        zeros_cfg = zeros;
        wait_left = waitc;
        reads_seen = 0;
        wr_cnt = 0;
        stall_cnt = 0;
        viol_both = 0;
        viol_gap = 0;
        viol_hold = 0;
        LOAD_PROFILE = 2'(prof);
        LOAD_REQ = 1'b1;
        @(negedge CLOCK);
        LOAD_REQ = 1'b0;
        check("busy after accept", int'(BUSY), 1);
        check("error cleared on accept", int'(ERROR), 0);
        got = 0;
        for (int c = 0; c < 5000 && got == 0; c++) begin
            @(negedge CLOCK);
            if (mid && c == 4) begin
                // Ignored request plus a rewrite of the last entry of the active profile.
                LOAD_REQ = 1'b1;
                LOAD_PROFILE = 2'd1;
                WE = 1'b1;
                WR_PROFILE = 2'(prof);
                WR_INDEX = 3'd7;
                WR_ENTRY = make_entry(6'h0A, 9'h155);
                sh_addr[prof][7] = 6'h0A;
                sh_data[prof][7] = 9'h155;
            end else if (mid && c == 5) begin
                LOAD_REQ = 1'b0;
                WE = 1'b0;
            end
            if (DONE) begin
                got = 1;
                check("busy low with done", int'(BUSY), 0);
                check("no error with done", int'(ERROR), 0);
            end else if (ERROR) begin
                got = 2;
                check("busy low with error", int'(BUSY), 0);
            end
        end
        check("load outcome (1=done 2=error 0=hung)", got, exp_err ? 2 : 1);
        @(negedge CLOCK);
        check("done pulse one cycle", int'(DONE), 0);
        @(negedge CLOCK);
        check("idle after load", int'(BUSY), 0);
        check("reads issued", reads_seen, exp_err ? TIMEOUT : zeros + 1);
        n = 0;
        for (int i = 0; i < 8; i++) begin
            if (sh_addr[prof][i] == END_MARKER) break;
            ea[n] = sh_addr[prof][i];
            ed[n] = sh_data[prof][i];
            n++;
        end
        ea[n] = 6'h02;
        ed[n] = 9'h001;
        check("writes issued", wr_cnt, n + 1);
        for (int i = 0; i <= n && i < wr_cnt; i++) begin
            check($sformatf("write %0d addr", i), int'(wr_addr_log[i]), int'(ea[i]));
            check($sformatf("write %0d data", i), int'(wr_data_log[i]), int'(ed[i]));
        end
        check("stall cycles seen", stall_cnt, waitc);
        check("write+read overlap", viol_both, 0);
        check("read gap between polls", viol_gap, 0);
        check("hold during waitrequest", viol_hold, 0);
    endtask

    typedef struct {
        int prof;
        int zeros;
        int waitc;
        bit exp_err;
        bit mid;
    } vec_t;

    vec_t vecs [6];

    initial begin
        vecs[0] = '{1, 0, 0, 1'b0, 1'b0};      // short profile, no stalls
        vecs[1] = '{1, 0, 4, 1'b0, 1'b0};      // first write stalled 4 cycles
        vecs[2] = '{2, 2, 0, 1'b0, 1'b0};      // full profile, two not-done polls
        vecs[3] = '{0, 0, 0, 1'b0, 1'b0};      // end marker at index 0
        vecs[4] = '{0, 100000, 0, 1'b1, 1'b0}; // status never done -> timeout
        vecs[5] = '{2, 0, 0, 1'b0, 1'b1};      // ignored request + mid-load write

        for (int p = 0; p < 4; p++)
            for (int i = 0; i < 8; i++) begin
                sh_addr[p][i] = END_MARKER;
                sh_data[p][i] = '0;
            end

        repeat (3) @(negedge CLOCK);
        check_all_zero("reset");
        RESET = 1'b0;
        @(negedge CLOCK);
        check_all_zero("after reset");

        write_entry(1, 0, 6'h03, 9'h1A5);
        write_entry(1, 1, 6'h04, 9'h0FF);
        write_entry(1, 2, END_MARKER, 9'h000);
        write_entry(0, 0, END_MARKER, 9'h000);
        for (int i = 0; i < 8; i++)
            write_entry(2, i, 6'(8 + i), 9'(i * 8'h23 + 8'h11));
        // Entries left unwritten in hardware; a full profile must not read them.
        write_entry(3, 0, END_MARKER, 9'h000);

        for (int v = 0; v < 6; v++) begin
            run_load(vecs[v].prof, vecs[v].zeros, vecs[v].waitc, vecs[v].exp_err, vecs[v].mid);
            if (vecs[v].exp_err) begin
                repeat (3) @(negedge CLOCK);
                check("error sticky in idle", int'(ERROR), 1);
                check("busy low in idle", int'(BUSY), 0);
            end
        end

        // Reset during the second data write of profile 1.
        begin
            int found = 0;
            int traffic = 0;
            @(negedge CLOCK);
            zeros_cfg = 0;
            wait_left = 0;
            LOAD_PROFILE = 2'd1;
            LOAD_REQ = 1'b1;
            @(negedge CLOCK);
            LOAD_REQ = 1'b0;
            for (int c = 0; c < 100 && found == 0; c++) begin
                @(negedge CLOCK);
                if (MGMT_WRITE && MGMT_ADDRESS == 6'h04) found = 1;
            end
            check("reached second write", found, 1);
            RESET = 1'b1;
            @(negedge CLOCK);
            RESET = 1'b0;
            check_all_zero("mid-transfer reset");
            repeat (6) begin
                @(negedge CLOCK);
                if (MGMT_WRITE || MGMT_READ || BUSY) traffic++;
            end
            check("traffic after reset", traffic, 0);
        end
        run_load(1, 0, 0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
